// File: rtl/branch_predict_ctrl.sv
// ---------------------------------------------------------------------------
// branch_predict_ctrl
//
// Dynamic branch predictor and misprediction-recovery controller for the
// 5-stage MIPS pipeline. A bimodal table of 2-bit saturating counters is
// looked up with the decode-stage PC to give a taken/not-taken prediction.
// The predicted branch is remembered while it travels from D into E; when E
// resolves it, the actual outcome is compared with the remembered prediction
// to steer the branch mux, request a flush, train the table and bump the
// statistics counters.
//
// Ports:
//   clk         pipeline clock
//   rst_n       asynchronous active-low reset
//   stallD      D->E pipeline register held this cycle
//   branchD     instruction in D is a conditional branch
//   pcD         PC of the instruction in D
//   resolveE    branch in E resolves this cycle
//   takenE      actual outcome of the E-stage branch (valid with resolveE)
//   stat_clr    synchronous clear of both statistics counters
//   brbitD      prediction for the D-stage instruction (1 = taken)
//   predtakenD  redirect fetch to the predicted target
//   brmuxsel    0 = no override, 1 = recover to target, 2 = recover to PC+4
//   flush       kill the wrong-path instructions in F and D
//   br_count    number of resolved branches (saturating)
//   mis_count   number of mispredicted branches (saturating)
// ---------------------------------------------------------------------------
module branch_predict_ctrl #(
    parameter int IDX_W = 4,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stallD,
    input  logic             branchD,
    input  logic [PC_W-1:0]  pcD,
    input  logic             resolveE,
    input  logic             takenE,
    input  logic             stat_clr,
    output logic             brbitD,
    output logic             predtakenD,
    output logic [1:0]       brmuxsel,
    output logic             flush,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mis_count
);

    localparam int ENTRIES = 2 ** IDX_W;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } pendState_t;

    pendState_t       state;
    pendState_t       stateNext;
    logic [1:0]       predTable [ENTRIES];
    logic [IDX_W-1:0] lookupIdx;
    logic [IDX_W-1:0] pendIdx;
    logic             pendPred;
    logic             res;
    logic             mis;
    logic             capture;
    logic             unusedPcBits;

    // Instructions are word aligned, so the two low PC bits never vary; the
    // table is indexed by the word address bits just above them. The bits
    // outside that window are folded into a dummy signal so they are visibly
    // consumed.
    assign lookupIdx    = pcD[IDX_W+1:2];
    assign unusedPcBits = ^{pcD[PC_W-1:IDX_W+2], pcD[1:0]};

    // Lookup, resolution and next-state logic. A resolveE without a pending
    // branch is a stray and is ignored completely. On a mispredict the
    // instruction sitting in D is on the wrong path, so it must neither
    // redirect fetch nor be captured as the next pending branch. The lookup
    // deliberately reads the table before this cycle's training write, even
    // when both touch the same entry. A resolution always consumes the
    // pending entry, even in a stalled cycle; otherwise a stall holds it.
    always_comb begin
        stateNext  = state;
        brbitD     = predTable[lookupIdx][1];
        res        = resolveE & (state == PEND);
        mis        = res & (takenE != pendPred);
        flush      = mis;
        brmuxsel   = 2'd0;
        predtakenD = branchD & brbitD & ~mis;
        capture    = ~stallD & branchD & ~mis;

        if (mis) begin
            brmuxsel = takenE ? 2'd1 : 2'd2;
        end

        if (capture) begin
            stateNext = PEND;
        end else if (res || !stallD) begin
            stateNext = IDLE;
        end
    end

    // Pending-branch register: the state bit says whether a predicted branch
    // is in flight, and its table index and prediction are latched only when
    // a new branch is captured so they stay stable across stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pendIdx  <= '0;
            pendPred <= 1'b0;
        end else begin
            state <= stateNext;
            if (capture) begin
                pendIdx  <= lookupIdx;
                pendPred <= brbitD;
            end
        end
    end

    // Table training: move the resolved entry one step toward the actual
    // outcome, sticking at strongly-taken / strongly-not-taken. Reset puts
    // every entry at weakly not-taken so a cold branch falls through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                predTable[i] <= 2'b01;
            end
        end else if (res) begin
            if (takenE && predTable[pendIdx] != 2'b11) begin
                predTable[pendIdx] <= predTable[pendIdx] + 2'd1;
            end else if (!takenE && predTable[pendIdx] != 2'b00) begin
                predTable[pendIdx] <= predTable[pendIdx] - 2'd1;
            end
        end
    end

    // Statistics: count every real resolution and every mispredict, holding
    // at all-ones rather than wrapping. A clear wins over a same-cycle count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count  <= '0;
            mis_count <= '0;
        end else if (stat_clr) begin
            br_count  <= '0;
            mis_count <= '0;
        end else begin
            if (res && br_count != '1) begin
                br_count <= br_count + CNT_W'(1);
            end
            if (mis && mis_count != '1) begin
                mis_count <= mis_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_predict_ctrl
//
// Directed bench for branch_predict_ctrl. Inputs change just after a rising
// edge and outputs are sampled on the following falling edge. Expected
// values are worked out by hand from the predictor behaviour. Note that
// with IDX_W = 4 both 0x40 and 0x80 map to table entry 0, 0x44 to entry 1
// and 0x48 to entry 2.
// ---------------------------------------------------------------------------
module tb_branch_predict_ctrl;

    logic        clk;
    logic        rst_n;
    logic        stallD;
    logic        branchD;
    logic [31:0] pcD;
    logic        resolveE;
    logic        takenE;
    logic        stat_clr;
    logic        brbitD;
    logic        predtakenD;
    logic [1:0]  brmuxsel;
    logic        flush;
    logic [15:0] br_count;
    logic [15:0] mis_count;

    int checkCount;
    int passCount;

    branch_predict_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stallD     (stallD),
        .branchD    (branchD),
        .pcD        (pcD),
        .resolveE   (resolveE),
        .takenE     (takenE),
        .stat_clr   (stat_clr),
        .brbitD     (brbitD),
        .predtakenD (predtakenD),
        .brmuxsel   (brmuxsel),
        .flush      (flush),
        .br_count   (br_count),
        .mis_count  (mis_count)
    );

    // 10 ns free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end else begin
            passCount++;
        end
    endtask

    // Drive one cycle's inputs, then wait for the sampling (falling) edge
    task automatic applyStimulus(input logic stall, input logic br, input logic [31:0] pc,
                                 input logic resolve, input logic taken, input logic clr);
        stallD   = stall;
        branchD  = br;
        pcD      = pc;
        resolveE = resolve;
        takenE   = taken;
        stat_clr = clr;
        @(negedge clk);
    endtask

    // Step past the next rising edge
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResolve(input string tag, input logic expFlush, input logic [1:0] expSel);
        checkOutput({tag, "_flush"}, 32'(flush), 32'(expFlush));
        checkOutput({tag, "_sel"}, 32'(brmuxsel), 32'(expSel));
    endtask

    task automatic checkCounts(input string tag, input logic [15:0] expBr, input logic [15:0] expMis);
        checkOutput({tag, "_br"}, 32'(br_count), 32'(expBr));
        checkOutput({tag, "_mis"}, 32'(mis_count), 32'(expMis));
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;

        // Reset with a branch presented in D
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_brbit", 32'(brbitD), 32'd0);
        checkOutput("rst_predtaken", 32'(predtakenD), 32'd0);
        checkResolve("rst", 1'b0, 2'd0);
        checkCounts("rst", 16'd0, 16'd0);
        rst_n = 1'b1;
        nextCycle();

        // Cold branch at 0x40 predicted not-taken, captured
        applyStimulus(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
        checkOutput("cold_brbit", 32'(brbitD), 32'd0);
        checkOutput("cold_predtaken", 32'(predtakenD), 32'd0);
        nextCycle();
        // Resolves taken: mispredict, recover to target; entry 0 -> 10
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        checkResolve("mis1", 1'b1, 2'd1);
        nextCycle();
        // Now predicted taken; captured with pred 1
        applyStimulus(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
        checkCounts("mis1", 16'd1, 16'd1);
        checkOutput("warm_brbit", 32'(brbitD), 32'd1);
        checkOutput("warm_predtaken", 32'(predtakenD), 32'd1);
        nextCycle();

        // Three back-to-back correct taken resolutions; entry 10 -> 11 -> 11
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 1'b0);
            checkResolve($sformatf("taken%0d", i), 1'b0, 2'd0);
            checkOutput($sformatf("taken%0d_brbit", i), 32'(brbitD), 32'd1);
            nextCycle();
        end
        // Not-taken resolution: recover to PC+4; entry 11 -> 10
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkResolve("mis2", 1'b1, 2'd2);
        nextCycle();
        // Entry 10 still predicts taken; capture again
        applyStimulus(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
        checkCounts("mis2", 16'd5, 16'd2);
        checkOutput("sat_brbit", 32'(brbitD), 32'd1);
        nextCycle();

        // Mispredict while 0x80 sits in D: wrong-path, not captured; entry 10 -> 01
        applyStimulus(1'b0, 1'b1, 32'h80, 1'b1, 1'b0, 1'b0);
        checkResolve("wrongpath", 1'b1, 2'd2);
        checkOutput("wrongpath_brbit", 32'(brbitD), 32'd1);
        checkOutput("wrongpath_predtaken", 32'(predtakenD), 32'd0);
        nextCycle();
        // Stray resolve with nothing pending is ignored
        applyStimulus(1'b0, 1'b0, 32'h40, 1'b1, 1'b1, 1'b0);
        checkResolve("stray", 1'b0, 2'd0);
        checkOutput("stray_brbit", 32'(brbitD), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h40, 1'b0, 1'b0, 1'b0);
        checkCounts("stray", 16'd6, 16'd3);
        nextCycle();

        // Capture 0x44 (pred 0), then hold it through a 3-cycle stall
        applyStimulus(1'b0, 1'b1, 32'h44, 1'b0, 1'b0, 1'b0);
        nextCycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 32'h48, 1'b0, 1'b0, 1'b0);
            checkResolve($sformatf("stall%0d", i), 1'b0, 2'd0);
            nextCycle();
        end
        // Correct not-taken resolution after the stall
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkResolve("poststall", 1'b0, 2'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkCounts("poststall", 16'd7, 16'd3);
        nextCycle();

        // Drive br_count to 0xFFFF with correct not-taken branches at 0x48
        applyStimulus(1'b0, 1'b1, 32'h48, 1'b0, 1'b0, 1'b0);
        nextCycle();
        for (int i = 0; i < 65528; i++) begin
            applyStimulus(1'b0, 1'b1, 32'h48, 1'b1, 1'b0, 1'b0);
            nextCycle();
        end
        applyStimulus(1'b0, 1'b1, 32'h48, 1'b1, 1'b0, 1'b0);
        checkCounts("full", 16'hFFFF, 16'd3);
        checkResolve("full", 1'b0, 2'd0);
        nextCycle();
        // Pending pred 0 resolved taken with stat_clr: clear beats increment
        applyStimulus(1'b0, 1'b0, 32'h48, 1'b1, 1'b1, 1'b1);
        checkCounts("saturate", 16'hFFFF, 16'd3);
        checkResolve("clrmis", 1'b1, 2'd1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h48, 1'b0, 1'b0, 1'b0);
        checkCounts("clr", 16'd0, 16'd0);
        checkOutput("clr_brbit", 32'(brbitD), 32'd0);
        nextCycle();

        // Train entry 0 to 10, capture it, then reset asynchronously mid-cycle
        applyStimulus(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
        checkOutput("pre_rst_brbit", 32'(brbitD), 32'd1);
        nextCycle();
        resolveE = 1'b1;
        takenE   = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_brbit", 32'(brbitD), 32'd0);
        checkOutput("async_rst_predtaken", 32'(predtakenD), 32'd0);
        checkResolve("async_rst", 1'b0, 2'd0);
        checkCounts("async_rst", 16'd0, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nextCycle();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
- Dynamic branch prediction and misprediction-recovery controller for the 5-stage MIPS pipeline.
- Holds a bimodal table of 2-bit saturating counters indexed by the decode-stage PC and supplies the D-stage prediction bit.
- Tracks the in-flight branch from D into E and, on resolution, drives the branch-mux select and the flush request.
- Trains the table and keeps saturating branch and mispredict statistics counters.

Parameters:
- IDX_W, 4, table index width; table has 2**IDX_W entries, indexed by pcD[IDX_W+1:2].
- PC_W, 32, program-counter width.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- stallD  in  1  D->E pipeline register held this cycle.
- branchD  in  1  instruction in D is a conditional branch.
- pcD  in  PC_W  PC of the instruction in D.
- resolveE  in  1  branch in E resolves this cycle.
- takenE  in  1  actual outcome of the E-stage branch; valid when resolveE=1.
- stat_clr  in  1  synchronous clear of both statistics counters.
- brbitD  out  1  prediction for the D-stage branch (1 = taken).
- predtakenD  out  1  redirect fetch to the predicted target.
- brmuxsel  out  2  0 = sequential / no override, 1 = recover to branch target, 2 = recover to branch PC+4.
- flush  out  1  kill the wrong-path instructions in F and D.
- br_count  out  CNT_W  resolved branches.
- mis_count  out  CNT_W  mispredicted branches.

Behaviour:
- Clocking and reset: all state on posedge clk; asynchronous clear on negedge rst_n.
- Reset values:
  - every table entry = 2'b01 (weakly not-taken);
  - pend_valid = 0, pend_idx = 0, pend_pred = 0;
  - br_count = 0, mis_count = 0.
  - Combinational outputs derived from reset state: brbitD = 0 (table entry bit 1), brmuxsel = 0, flush = 0, predtakenD = 0.
- Lookup (combinational, zero latency):
  - brbitD = table[pcD[IDX_W+1:2]][1], whether or not branchD is asserted.
  - predtakenD = branchD & brbitD & ~flush.
- Capture into pending (clock edge):
  - Condition: ~stallD, branchD, and ~flush.
  - Action: pend_valid <= 1, pend_idx <= lookup index, pend_pred <= brbitD.
- Pending otherwise:
  - If ~stallD and no capture: pend_valid <= 0.
  - If stallD: pend_valid/pend_idx/pend_pred hold.
- Resolution:
  - res = resolveE & pend_valid. resolveE with pend_valid=0 is ignored: no update, no flush, counters unchanged.
  - mis = res & (takenE != pend_pred).
  - flush = mis.
  - brmuxsel = 1 if mis & takenE; 2 if mis & ~takenE; else 0.
- Training (clock edge, when res=1):
  - table[pend_idx] increments toward 2'b11 if takenE, decrements toward 2'b00 if ~takenE.
  - Saturates at both ends; no wrap.
  - Consumes the pending entry: pend_valid <= 0 unless a new capture occurs in the same cycle.
- Same-cycle conflicts:
  - Resolution and capture in the same cycle with the same index: the lookup returns the pre-update value; no bypass.
  - If mis=1, the D-stage branch is wrong-path: it is not captured, and predtakenD is forced to 0.
  - A non-mispredicting resolution and a new capture in the same cycle: the new branch is captured normally.
- Statistics (clock edge):
  - br_count increments on res; mis_count increments on mis.
  - Both saturate at all-ones.
  - stat_clr has priority over increment in the same cycle.
- Effective states: IDLE (pend_valid=0) and PEND (pend_valid=1).
  - IDLE -> PEND on capture.
  - PEND -> IDLE on resolution without a new capture, or on ~stallD without a capture.
  - PEND -> PEND on stall or on back-to-back branches.
- Reset mid-operation: pending branch dropped, table returns to weakly not-taken, counters cleared, outputs immediately at reset values.

Test Plan:
- Reset with branchD=1, pcD=0x40 -> brbitD=0, predtakenD=0, brmuxsel=0, flush=0, br_count=0, mis_count=0.
- Branch at pcD=0x40 captured, next cycle resolveE=1, takenE=1 -> flush=1, brmuxsel=1, entry 0 becomes 2'b10, mis_count=1, br_count=1; next lookup of 0x40 gives brbitD=1, predtakenD=1.
- Three more taken resolutions at 0x40 -> entry saturates at 2'b11, no flush; then one not-taken -> flush=1, brmuxsel=2, entry becomes 2'b10.
- Mispredict in E while branchD=1 at pcD=0x80 in D -> 0x80 not captured, predtakenD=0, pend_valid=0 next cycle; a later resolveE=1 is ignored with counters unchanged.
- stallD=1 for 3 cycles with a pending branch and resolveE=0 -> pending holds; resolveE=1 with takenE matching the prediction after the stall -> br_count+1, flush=0.
- Preload br_count=0xFFFF by 65535 correct resolutions, then one more -> stays 0xFFFF; stat_clr together with res -> both counters 0; rst_n pulsed mid-run -> all state at reset values asynchronously.
